// File: rtl/jt5205_feed_pkg.sv
// jt5205_feed_pkg: state encoding, widths and nibble-order helper for the jt5205 ROM feeder
package jt5205_feed_pkg;
  typedef enum logic [1:0] {IDLE, PREFETCH, PLAY} state_t;
  localparam bit HIGH_FIRST_DEF = 1'b1;
  localparam int DIN_W = 4;
  localparam int DATA_W = 8;
  function automatic logic [DIN_W-1:0] nibble(input logic [DATA_W-1:0] b, input logic second, input logic high_first);
    return (second ^ high_first) ? b[7:4] : b[3:0];
  endfunction
endpackage

// File: rtl/jt5205_romfeed_if.sv
// jt5205_romfeed_if: sample ROM request/acknowledge bus between feeder (master) and ROM (slave)
interface jt5205_romfeed_if import jt5205_feed_pkg::*; #(parameter int AW = 16);
  logic [AW-1:0] addr;
  logic cs;
  logic [DATA_W-1:0] data;
  logic ok;
  modport master (output addr, cs, input data, ok);
  modport slave (input addr, cs, output data, ok);
endinterface

// File: rtl/jt5205_feed_fetch.sv
// jt5205_feed_fetch: ROM handshake, wrapping address counter, 1-byte buffer and in-flight discard
module jt5205_feed_fetch import jt5205_feed_pkg::*; #(parameter int AW = 16) (
  input  logic clk,
  input  logic rst,
  jt5205_romfeed_if.master rom,
  input  logic en,
  input  logic load,
  input  logic reload,
  input  logic flush,
  input  logic take,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic buf_valid,
  output logic all_fetched,
  output logic cap
);
  logic [AW-1:0] addr, end_r, start_r;
  logic cs, discard;
  assign rom.addr = addr;
  assign rom.cs = cs;
  assign cap = cs && rom.ok && !discard;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      end_r <= '0;
      start_r <= '0;
      cs <= 1'b0;
      discard <= 1'b0;
      buf_data <= '0;
      buf_valid <= 1'b0;
      all_fetched <= 1'b0;
    end else begin
      if (cs && rom.ok) begin
        cs <= 1'b0;
        discard <= 1'b0;
        if (!discard) begin
          buf_data <= rom.data;
          buf_valid <= 1'b1;
          all_fetched <= addr == end_r;
          addr <= addr + 1'b1;
        end
      end else if (en && !cs && !buf_valid && !all_fetched) cs <= 1'b1;
      if (take) buf_valid <= 1'b0;
      if (reload) begin
        addr <= start_r;
        all_fetched <= 1'b0;
      end
      // an aborted request keeps cs up until the ROM answers, then drops its data
      if (flush) begin
        buf_valid <= 1'b0;
        if (cs && !rom.ok) discard <= 1'b1;
      end
      if (load) begin
        addr <= start_addr;
        start_r <= start_addr;
        end_r <= end_addr;
        all_fetched <= 1'b0;
        buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/jt5205_romfeed.sv
// jt5205_romfeed: streams ROM bytes as 4-bit ADPCM codes to a jt5205 decoder
// Optional sample looping with JT5205_FEED_LOOP_EN (adds the loop port).
module jt5205_romfeed import jt5205_feed_pkg::*; #(
  parameter int AW = 16,
  parameter bit HIGH_FIRST = HIGH_FIRST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cen_lo,
  input  logic start,
  input  logic stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  jt5205_romfeed_if.master rom,
  output logic [DIN_W-1:0] din,
  output logic adpcm_rst,
  output logic busy,
  output logic done,
  output logic underrun
`ifdef JT5205_FEED_LOOP_EN
  ,
  input  logic loop
`endif
);
  state_t state;
  logic phase, pend, lp;
  logic [DATA_W-1:0] shift, buf_data;
  logic buf_valid, all_fetched, cap;
  logic go, abort, flush, act, take, fin, en;
`ifdef JT5205_FEED_LOOP_EN
  assign lp = loop;
`else
  assign lp = 1'b0;
`endif
  always_comb begin
    go = state == IDLE && (start || pend) && !stop && !rom.cs;
    abort = state != IDLE && pend && !rom.cs;
    flush = state != IDLE && (stop || abort);
    en = state != IDLE && !flush;
    act = state == PLAY && cen_lo && !phase && !flush;
    take = act && buf_valid;
    fin = act && !buf_valid && all_fetched;
  end
  jt5205_feed_fetch #(.AW(AW)) u_fetch (
    .clk(clk),
    .rst(rst),
    .rom(rom),
    .en(en),
    .load(go),
    .reload(fin && lp),
    .flush(flush),
    .take(take),
    .start_addr(start_addr),
    .end_addr(end_addr),
    .buf_data(buf_data),
    .buf_valid(buf_valid),
    .all_fetched(all_fetched),
    .cap(cap)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      pend <= 1'b0;
      shift <= '0;
      din <= '0;
      done <= 1'b0;
      underrun <= 1'b0;
      busy <= 1'b0;
      adpcm_rst <= 1'b1;
    end else begin
      done <= 1'b0;
      // a pending restart survives the abort and is taken up from IDLE
      if (stop || abort) begin
        pend <= pend && !stop;
        if (state != IDLE) begin
          state <= IDLE;
          adpcm_rst <= 1'b1;
          busy <= 1'b0;
          phase <= 1'b0;
        end
      end else if (go) begin
        state <= PREFETCH;
        busy <= 1'b1;
        underrun <= 1'b0;
        pend <= 1'b0;
        phase <= 1'b0;
      end else begin
        if (start) pend <= 1'b1;
        if (state == PREFETCH && cap) state <= PLAY;
        if (state == PLAY) adpcm_rst <= 1'b0;
        if (take) begin
          shift <= buf_data;
          din <= nibble(buf_data, 1'b0, HIGH_FIRST);
          phase <= 1'b1;
        end
        if (state == PLAY && cen_lo && phase) begin
          din <= nibble(shift, 1'b1, HIGH_FIRST);
          phase <= 1'b0;
        end
        if (act && !buf_valid && !all_fetched) underrun <= 1'b1;
        if (fin) begin
          done <= 1'b1;
          if (!lp) begin
            state <= IDLE;
            adpcm_rst <= 1'b1;
            busy <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_jt5205_romfeed.sv
// tb_jt5205_romfeed: directed bench for the ROM feeder, high- and low-nibble-first instances side by side
module tb_jt5205_romfeed;
  localparam int GAP = 8;
  logic clk = 1'b0, rst = 1'b1, cen_lo = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] start_addr = '0, end_addr = '0;
  logic [3:0] din_hi, din_lo;
  logic arst_hi, arst_lo, busy_hi, busy_lo, done_hi, done_lo, urun_hi, urun_lo;
`ifdef JT5205_FEED_LOOP_EN
  logic loop = 1'b0;
`endif
  bit [7:0] mem [0:65535];
  int checks = 0, errors = 0, acks = 0, done_cnt = 0, slow_addr = -1, slow_lat = 2;
  int ncen, d0;
  bit seen;
  logic [15:0] ack_q[$];
  logic [3:0] hi_log[$], lo_log[$];
  jt5205_romfeed_if #(.AW(16)) rom_hi();
  jt5205_romfeed_if #(.AW(16)) rom_lo();
  jt5205_romfeed #(.AW(16), .HIGH_FIRST(1'b1)) u_hi (
    .clk(clk), .rst(rst), .cen_lo(cen_lo), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom(rom_hi),
    .din(din_hi), .adpcm_rst(arst_hi), .busy(busy_hi), .done(done_hi), .underrun(urun_hi)
`ifdef JT5205_FEED_LOOP_EN
    , .loop(loop)
`endif
  );
  jt5205_romfeed #(.AW(16), .HIGH_FIRST(1'b0)) u_lo (
    .clk(clk), .rst(rst), .cen_lo(cen_lo), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom(rom_lo),
    .din(din_lo), .adpcm_rst(arst_lo), .busy(busy_lo), .done(done_lo), .underrun(urun_lo)
`ifdef JT5205_FEED_LOOP_EN
    , .loop(loop)
`endif
  );
  always #5 clk = ~clk;
  // ROM model: answers the high-first instance's request after a per-address latency, mirrored to both
  initial begin
    int cnt, lat;
    cnt = 0;
    rom_hi.ok = 1'b0; rom_lo.ok = 1'b0; rom_hi.data = '0; rom_lo.data = '0;
    forever begin
      @(negedge clk);
      rom_hi.ok = 1'b0; rom_lo.ok = 1'b0;
      if (rom_hi.cs) begin
        cnt++;
        lat = (int'(rom_hi.addr) == slow_addr) ? slow_lat : 2;
        if (cnt >= lat) begin
          rom_hi.ok = 1'b1; rom_lo.ok = 1'b1;
          rom_hi.data = mem[rom_hi.addr]; rom_lo.data = mem[rom_hi.addr];
          ack_q.push_back(rom_hi.addr);
          acks++;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end
  initial begin
    logic [3:0] lh, ll;
    lh = '0; ll = '0;
    forever begin
      @(negedge clk);
      if (done_hi) done_cnt++;
      if (din_hi !== lh) begin hi_log.push_back(din_hi); lh = din_hi; end
      if (din_lo !== ll) begin lo_log.push_back(din_lo); ll = din_lo; end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_log(input string tag, input int n, input logic [47:0] eh, input logic [47:0] el);
    chk({tag, "_nh"}, hi_log.size(), n);
    chk({tag, "_nl"}, lo_log.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_hi%0d", tag, i), (i < hi_log.size()) ? hi_log[i] : 4'hx, eh[4*(n-1-i) +: 4]);
      chk($sformatf("%s_lo%0d", tag, i), (i < lo_log.size()) ? lo_log[i] : 4'hx, el[4*(n-1-i) +: 4]);
    end
  endtask
  task automatic clear_logs();
    hi_log.delete(); lo_log.delete(); ack_q.delete(); acks = 0;
  endtask
  task automatic go(input logic [15:0] sa, input logic [15:0] ea);
    @(negedge clk); start_addr = sa; end_addr = ea; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic run(input int max_cen, output int n, output bit s);
    n = 0; s = 1'b0;
    while (!s && n < max_cen) begin
      @(negedge clk); cen_lo = 1'b1;
      @(negedge clk); cen_lo = 1'b0;
      n++;
      if (done_hi) s = 1'b1;
      else repeat (GAP - 1) @(negedge clk);
    end
  endtask
  initial begin
    mem[16'h0100] = 8'hA5;
    mem[16'h0200] = 8'h12; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h56; mem[16'h0203] = 8'h78;
    mem[16'hFFFF] = 8'h9C; mem[16'h0000] = 8'h3E;
    mem[16'h0300] = 8'h1F; mem[16'h0301] = 8'h2E; mem[16'h0302] = 8'h3D;
    mem[16'h0400] = 8'h47; mem[16'h0401] = 8'h47; mem[16'h0500] = 8'h6B;
    mem[16'h0600] = 8'h12; mem[16'h0601] = 8'h34;
    repeat (3) @(negedge clk);
    chk("rst_cs", rom_hi.cs, 0);
    chk("rst_addr", rom_hi.addr, 0);
    chk("rst_din", din_hi, 0);
    chk("rst_done", done_hi, 0);
    chk("rst_urun", urun_hi, 0);
    chk("rst_busy", busy_hi, 0);
    chk("rst_arst", arst_hi, 1);
    rst = 1'b0;
    // single byte
    clear_logs();
    go(16'h0100, 16'h0100);
    chk("t1_arst_pre", arst_hi, 1);
    repeat (10) @(negedge clk);
    chk("t1_busy", busy_hi, 1);
    chk("t1_arst", arst_hi, 0);
    run(10, ncen, seen);
    chk("t1_seen", seen, 1);
    chk("t1_ncen", ncen, 3);
    chk("t1_busy_end", busy_hi, 0);
    chk("t1_arst_end", arst_hi, 1);
    @(negedge clk);
    chk("t1_done_1clk", done_hi, 0);
    check_log("t1", 2, 48'hA5, 48'h5A);
    // four bytes
    clear_logs();
    go(16'h0200, 16'h0203);
    repeat (10) @(negedge clk);
    run(20, ncen, seen);
    chk("t2_ncen", ncen, 9);
    chk("t2_acks", acks, 4);
    chk("t2_urun", urun_lo, 0);
    check_log("t2", 8, 48'h12345678, 48'h21436587);
    // address wrap
    clear_logs();
    go(16'hFFFF, 16'h0000);
    repeat (10) @(negedge clk);
    run(10, ncen, seen);
    chk("t3_ncen", ncen, 5);
    chk("t3_nack", ack_q.size(), 2);
    chk("t3_a0", (ack_q.size() > 0) ? ack_q[0] : 16'hx, 16'hFFFF);
    chk("t3_a1", (ack_q.size() > 1) ? ack_q[1] : 16'hx, 16'h0000);
    check_log("t3", 4, 48'h9C3E, 48'hC9E3);
    // slow ROM on the second byte
    clear_logs();
    slow_addr = 16'h0301; slow_lat = 40;
    go(16'h0300, 16'h0302);
    repeat (10) @(negedge clk);
    run(30, ncen, seen);
    chk("t4_seen", seen, 1);
    chk("t4_urun", urun_hi, 1);
    chk("t4_acks", acks, 3);
    check_log("t4", 6, 48'h1F2E3D, 48'hF1E2D3);
    // stop during an in-flight fetch, then a fresh start
    slow_addr = 16'h0400; slow_lat = 20;
    go(16'h0400, 16'h0401);
    @(negedge clk);
    chk("t5_cs", rom_hi.cs, 1);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    d0 = done_cnt;
    chk("t5_busy", busy_hi, 0);
    chk("t5_arst", arst_hi, 1);
    chk("t5_cs_held", rom_hi.cs, 1);
    repeat (30) @(negedge clk);
    chk("t5_cs_drop", rom_hi.cs, 0);
    chk("t5_nodone", done_cnt, d0);
    chk("t5_busy_late", busy_hi, 0);
    clear_logs();
    slow_addr = -1;
    go(16'h0500, 16'h0500);
    chk("t5_urun_clr", urun_hi, 0);
    repeat (10) @(negedge clk);
    run(10, ncen, seen);
    chk("t5_ncen", ncen, 3);
    check_log("t5", 2, 48'h6B, 48'hB6);
    // reset mid-operation
    go(16'h0200, 16'h0203);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_busy", busy_hi, 0);
    chk("t6_cs", rom_hi.cs, 0);
    chk("t6_arst", arst_hi, 1);
    chk("t6_din", din_hi, 0);
    repeat (10) @(negedge clk);
    chk("t6_cs_idle", rom_hi.cs, 0);
`ifdef JT5205_FEED_LOOP_EN
    clear_logs();
    loop = 1'b1;
    d0 = done_cnt;
    go(16'h0600, 16'h0601);
    repeat (10) @(negedge clk);
    run(12, ncen, seen);
    repeat (GAP - 1) @(negedge clk);
    run(7, ncen, seen);
    chk("t7_dones", done_cnt - d0, 2);
    chk("t7_arst", arst_hi, 0);
    chk("t7_busy", busy_hi, 1);
    chk("t7_urun", urun_hi, 0);
    check_log("t7", 8, 48'h12341234, 48'h21432143);
    loop = 1'b0;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
